fcvt_s_w_seq: RTL

//  Multi-cycle FCVT.S.W unit: converts a 32-bit signed integer to IEEE-754 single, round-to-nearest-even.

---
 rtl/fpu_pkg.sv | 9 +
 rtl/fpu_round_rne.sv | 21 ++
 rtl/fcvt_s_w_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants, converter FSM state type and canonical zero.
package fpu_pkg;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_INT_TOP = EXP_W'(BIAS + 31);
   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   typedef enum logic [2:0] {ST_IDLE, ST_ABS, ST_NORM, ST_ROUND, ST_DONE} fcvt_state_e;
endpackage

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: round-to-nearest-even of a normalized mantissa given guard and sticky bits.
module fpu_round_rne
   import fpu_pkg::*;
(
   input  logic [MAN_W-1:0] man_i,
   input  logic             g_i,
   input  logic             s_i,
   input  logic [EXP_W-1:0] exp_i,
   output logic [MAN_W-1:0] man_o,
   output logic [EXP_W-1:0] exp_o,
   output logic             inexact_o
);
   logic             inc;
   logic [MAN_W:0]   sum;
   assign inc = g_i & (s_i | man_i[0]);
   assign sum = {1'b0, man_i} + {{MAN_W{1'b0}}, inc};
   // a carry out leaves the low bits zero, so only the exponent needs bumping
   assign man_o = sum[MAN_W-1:0];
   assign exp_o = exp_i + {{(EXP_W-1){1'b0}}, sum[MAN_W]};
   assign inexact_o = g_i | s_i;
endmodule

// File: rtl/fcvt_s_w_seq.sv
// fcvt_s_w_seq: iterative int32 -> IEEE-754 single converter (RNE) with valid/ready handshake.
// Define FCVT_WU_EN to add the in_unsigned port for FCVT.S.WU.
module fcvt_s_w_seq
   import fpu_pkg::*;
#(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_int,
`ifdef FCVT_WU_EN
   input  logic        in_unsigned,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_inexact
);
   fcvt_state_e      state_q, state_d;
   logic [31:0]      mag_q, mag_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic             sign_q, sign_d;
   logic [31:0]      result_q, result_d;
   logic             inexact_q, inexact_d;
   logic             is_uns;
   logic [MAN_W-1:0] rman;
   logic [EXP_W-1:0] rexp;
   logic             rinx;
`ifdef FCVT_WU_EN
   logic             uns_q, uns_d;
   assign is_uns = uns_q;
`else
   assign is_uns = 1'b0;
`endif

   fpu_round_rne u_round (
      .man_i     (mag_q[30:8]),
      .g_i       (mag_q[7]),
      .s_i       (|mag_q[6:0]),
      .exp_i     (exp_q),
      .man_o     (rman),
      .exp_o     (rexp),
      .inexact_o (rinx)
   );

   assign in_ready    = (state_q == ST_IDLE);
   assign out_valid   = (state_q == ST_DONE);
   assign out_result  = result_q;
   assign out_inexact = inexact_q;

   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      exp_d     = exp_q;
      sign_d    = sign_q;
      result_d  = result_q;
      inexact_d = inexact_q;
`ifdef FCVT_WU_EN
      uns_d     = uns_q;
`endif
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (in_valid) begin
               mag_d   = in_int;
`ifdef FCVT_WU_EN
               uns_d   = in_unsigned;
`endif
               state_d = ST_ABS;
            end
            ST_ABS: begin
               sign_d  = ~is_uns & mag_q[31];
               mag_d   = sign_d ? -mag_q : mag_q;
               exp_d   = EXP_INT_TOP;
               // zero skips normalization; ROUND substitutes canonical +0
               state_d = (mag_d == '0) ? ST_ROUND : ST_NORM;
            end
            ST_NORM: if (mag_q[31]) begin
               state_d = ST_ROUND;
            end else if (mag_q[31 -: SHIFT_STEP] == '0) begin
               mag_d = mag_q << SHIFT_STEP;
               exp_d = exp_q - EXP_W'(SHIFT_STEP);
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 1'b1;
            end
            ST_ROUND: begin
               result_d  = (mag_q == '0) ? FP_POS_ZERO : {sign_q, rexp, rman};
               inexact_d = rinx;
               state_d   = ST_DONE;
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mag_q     <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         result_q  <= '0;
         inexact_q <= 1'b0;
`ifdef FCVT_WU_EN
         uns_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mag_q     <= mag_d;
         exp_q     <= exp_d;
         sign_q    <= sign_d;
         result_q  <= result_d;
         inexact_q <= inexact_d;
`ifdef FCVT_WU_EN
         uns_q     <= uns_d;
`endif
      end
   end
endmodule
